// File: rtl/vld_packer.sv
// Packs BeatsPerWord memory beats (beat 0 at LSB) into VRF words and buffers them in a small FIFO.
// Optional overrun check is enabled by defining VLD_PACKER_OVERRUN_CHK_EN.
module vld_packer #(
    parameter int unsigned BeatsPerWord = 2,
    parameter int unsigned BufDepth     = 4,
    parameter type         vrf_data_t   = logic [63:0],
    parameter type         word_cnt_t   = logic [7:0],
    parameter type         insn_id_t    = logic [3:0],
    parameter int unsigned BeatWidth    = $bits(vrf_data_t) / BeatsPerWord
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  word_cnt_t            cmd_word_cnt_i,
    input  insn_id_t             cmd_insn_id_i,
    input  logic                 mem_rvalid_i,
    output logic                 mem_rready_o,
    input  logic [BeatWidth-1:0] mem_rdata_i,
    output logic                 load_op_valid_o,
    input  logic                 load_op_ready_i,
    output vrf_data_t            load_op_o,
    output logic                 done_o,
    output insn_id_t             done_insn_id_o,
    output logic                 err_o
);

    localparam int unsigned BeatCntW = (BeatsPerWord > 1) ? $clog2(BeatsPerWord) : 1;
    localparam int unsigned PtrW     = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned CntW     = $clog2(BufDepth + 1);

    localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(BeatsPerWord - 1);
    localparam logic [PtrW-1:0]     LastPtr  = PtrW'(BufDepth - 1);
    localparam logic [CntW-1:0]     FullCnt  = CntW'(BufDepth);

    typedef enum logic {
        IDLE,
        PACK
    } state_e;

    state_e               state_q, state_d;
    logic [BeatCntW-1:0]  beat_cnt_q;
    word_cnt_t            words_left_q;
    word_cnt_t            pending_q;
    insn_id_t             id_q;
    vrf_data_t            partial_q;
    vrf_data_t            asm_word;

    vrf_data_t            fifo_mem [BufDepth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      fifo_cnt_q;

    logic                 cmd_fire;
    logic                 beat_fire;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;

    assign pop             = (fifo_cnt_q != '0) && load_op_ready_i;
    // A full FIFO still admits a beat when a word leaves in the same cycle.
    assign fifo_full       = (fifo_cnt_q == FullCnt) && !pop;
    assign mem_rready_o    = (state_q == PACK) && (words_left_q != '0) && !fifo_full;
    assign beat_fire       = mem_rvalid_i && mem_rready_o;
    assign push            = beat_fire && (beat_cnt_q == LastBeat);
    assign cmd_fire        = cmd_valid_i && cmd_ready_o;

    assign load_op_valid_o = (fifo_cnt_q != '0);
    assign load_op_o       = fifo_mem[rd_ptr_q];
    assign done_insn_id_o  = id_q;

    always_comb begin
        asm_word = partial_q;
        for (int unsigned k = 0; k < BeatsPerWord; k++) begin
            if (beat_cnt_q == BeatCntW'(k)) begin
                asm_word[k*BeatWidth +: BeatWidth] = mem_rdata_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                // An empty command completes on its first PACK cycle.
                if ((pending_q == '0) || (pop && (pending_q == word_cnt_t'(1)))) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_cnt_q   <= '0;
            words_left_q <= '0;
            pending_q    <= '0;
            id_q         <= '0;
            partial_q    <= '0;
        end else if (cmd_fire) begin
            beat_cnt_q   <= '0;
            words_left_q <= cmd_word_cnt_i;
            pending_q    <= cmd_word_cnt_i;
            id_q         <= cmd_insn_id_i;
            partial_q    <= '0;
        end else begin
            if (beat_fire) begin
                if (push) begin
                    beat_cnt_q   <= '0;
                    partial_q    <= '0;
                    words_left_q <= words_left_q - 1'b1;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                    partial_q  <= asm_word;
                end
            end
            if (pop) begin
                pending_q <= pending_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= asm_word;
        end
    end

`ifdef VLD_PACKER_OVERRUN_CHK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (mem_rvalid_i && ((state_q == IDLE) || (words_left_q == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
